// File: rtl/fft4_frame_loader.sv
// Serial-to-parallel ping-pong frame loader for the 4-point FFT input.
// Optional macro FFT4_LOADER_BITREV_EN presents frames in bit-reversed order.
module fft4_bank #(
    parameter int SW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [1:0]           i_idx,
    input  logic [SW-1:0]        i_din,
    output logic [3:0][SW-1:0]   o_q
);
    logic [3:0][SW-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_q        <= '0;
        else if (i_we) r_q[i_idx] <= i_din;
    end

    assign o_q = r_q;
endmodule

module fft4_frame_loader #(
    parameter int SW    = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    input  logic [SW-1:0]    s_data,
    output logic             s_ready,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [SW-1:0]    i0,
    output logic [SW-1:0]    i1,
    output logic [SW-1:0]    i2,
    output logic [SW-1:0]    i3,
    output logic [CNT_W-1:0] frame_cnt
);
    logic [1:0]             r_full;
    logic                   r_wr_sel;
    logic                   r_rd_sel;
    logic [1:0]             r_wr_idx;
    logic [CNT_W-1:0]       r_frame_cnt;

    logic                   w_s_ready;
    logic                   w_f_valid;
    logic                   w_accept;
    logic                   w_fill;
    logic                   w_consume;
    logic [1:0]             w_set;
    logic [1:0]             w_clr;
    logic [1:0][3:0][SW-1:0] w_bank_q;
    logic [3:0][SW-1:0]     w_rd_q;

    // Handshake flags come from registers only, so f_ready never reaches s_ready.
    assign w_s_ready = ~r_full[r_wr_sel];
    assign w_f_valid = r_full[r_rd_sel];
    assign w_accept  = s_valid && w_s_ready && !flush;
    assign w_fill    = w_accept && (r_wr_idx == 2'd3);
    assign w_consume = w_f_valid && f_ready;

    assign w_set = w_fill    ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr = w_consume ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            fft4_bank #(.SW(SW)) u_bank (
                .clk   (clk),
                .rst   (rst),
                .i_we  (w_accept && (r_wr_sel == 1'(b))),
                .i_idx (r_wr_idx),
                .i_din (s_data),
                .o_q   (w_bank_q[b])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full      <= 2'b00;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_wr_idx    <= 2'd0;
            r_frame_cnt <= '0;
        end else begin
            // Set and clear never hit the same bank: a fill needs it empty, a consume needs it full.
            r_full <= (r_full & ~w_clr) | w_set;
            if (flush)         r_wr_idx <= 2'd0;
            else if (w_accept) r_wr_idx <= r_wr_idx + 2'd1;
            if (w_fill)        r_wr_sel <= ~r_wr_sel;
            if (w_consume) begin
                r_rd_sel    <= ~r_rd_sel;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign w_rd_q = w_bank_q[r_rd_sel];

    assign s_ready   = w_s_ready;
    assign f_valid   = w_f_valid;
    assign frame_cnt = r_frame_cnt;

`ifdef FFT4_LOADER_BITREV_EN
    assign i0 = w_f_valid ? w_rd_q[0] : '0;
    assign i1 = w_f_valid ? w_rd_q[2] : '0;
    assign i2 = w_f_valid ? w_rd_q[1] : '0;
    assign i3 = w_f_valid ? w_rd_q[3] : '0;
`else
    assign i0 = w_f_valid ? w_rd_q[0] : '0;
    assign i1 = w_f_valid ? w_rd_q[1] : '0;
    assign i2 = w_f_valid ? w_rd_q[2] : '0;
    assign i3 = w_f_valid ? w_rd_q[3] : '0;
`endif
endmodule

// File: tb/tb_fft4_frame_loader.sv
// Bench for fft4_frame_loader: queue-based frame model checked every cycle,
// plus directed literal checks; a second instance with CNT_W=2 covers wrap.
module tb_fft4_frame_loader;
    localparam int SW = 2;
    typedef logic signed [SW-1:0] samp_t;

    logic clk = 0;
    logic rst = 0;
    logic flush = 0;
    logic s_valid = 0;
    logic [SW-1:0] s_data = '0;
    logic f_ready = 0;

    logic s_ready, f_valid;
    logic [SW-1:0] i0, i1, i2, i3;
    logic [7:0] frame_cnt;
    logic s_ready2, f_valid2;
    logic [SW-1:0] j0, j1, j2, j3;
    logic [1:0] frame_cnt2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fft4_frame_loader #(.SW(SW), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .f_valid(f_valid), .f_ready(f_ready),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .frame_cnt(frame_cnt));

    fft4_frame_loader #(.SW(SW), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready2), .f_valid(f_valid2), .f_ready(f_ready),
        .i0(j0), .i1(j1), .i2(j2), .i3(j3), .frame_cnt(frame_cnt2));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: pending partial samples and a flat queue of completed frames (4 per frame).
    samp_t pq[$];
    samp_t fq[$];
    int    mcnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pq.delete(); fq.delete(); mcnt = 0;
        end else begin
            automatic bit acc = s_valid && (fq.size() < 8) && !flush;
            automatic bit con = (fq.size() > 0) && f_ready;
            if (flush) pq.delete();
            if (con) begin
                repeat (4) void'(fq.pop_front());
                mcnt++;
            end
            if (acc) begin
                pq.push_back(samp_t'(s_data));
                if (pq.size() == 4) begin
                    foreach (pq[k]) fq.push_back(pq[k]);
                    pq.delete();
                end
            end
        end
    end

    function automatic logic [SW-1:0] exp_i(input int k);
        int p;
`ifdef FFT4_LOADER_BITREV_EN
        p = (k == 1) ? 2 : (k == 2) ? 1 : k;
`else
        p = k;
`endif
        return (fq.size() > 0) ? fq[p] : '0;
    endfunction

    always @(negedge clk) begin
        automatic logic ers = (fq.size() < 8);
        automatic logic efv = (fq.size() > 0);
        automatic logic [SW*4-1:0] ei = {exp_i(0), exp_i(1), exp_i(2), exp_i(3)};
        chk("model_main", {ers, efv, i0, i1, i2, i3, frame_cnt},
            {ers, efv, ei, 8'(mcnt)});
        chk("model_wrap", {s_ready2, f_valid2, j0, j1, j2, j3, frame_cnt2},
            {ers, efv, ei, 2'(mcnt)});
    end

    task automatic put(input samp_t v);
        s_valid = 1; s_data = v;
        for (int k = 0; k < 50 && !s_ready; k++) @(negedge clk);
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL put_timeout got=s_ready0 exp=s_ready1 t=%0t", $time);
        end
        @(negedge clk);
        s_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 1;
        @(negedge clk); rst = 0;
    endtask

    int c0;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        // 1: reset mid-frame
        do_reset();
        put(1); put(-1);
        #2 rst = 1; #1;
        chk("rst_outputs", {s_ready, f_valid, i0, i1, i2, i3, frame_cnt}, {1'b1, 1'b0, 8'h00, 8'h00});
        @(negedge clk); rst = 0;

        // 2: single frame, held without f_ready
        put(1); put(-1); put(-2); put(0);
        chk("f2_valid", f_valid, 1);
`ifdef FFT4_LOADER_BITREV_EN
        chk("f2_data", {i0, i1, i2, i3}, {2'b01, 2'b10, 2'b11, 2'b00});
`else
        chk("f2_data", {i0, i1, i2, i3}, {2'b01, 2'b11, 2'b10, 2'b00});
`endif
        repeat (3) @(negedge clk);
`ifdef FFT4_LOADER_BITREV_EN
        chk("f2_hold", {f_valid, i0, i1, i2, i3}, {1'b1, 2'b01, 2'b10, 2'b11, 2'b00});
`else
        chk("f2_hold", {f_valid, i0, i1, i2, i3}, {1'b1, 2'b01, 2'b11, 2'b10, 2'b00});
`endif

        // 3: backpressure
        do_reset();
        for (int k = 0; k < 8; k++) put(samp_t'(k));
        chk("bp_sready_low", s_ready, 0);
        s_valid = 1; s_data = 2'b10;
        repeat (2) @(negedge clk);
        chk("bp_held", {s_ready, frame_cnt}, {1'b0, 8'd0});
        f_ready = 1;
        @(negedge clk); f_ready = 0;
        chk("bp_release", {s_ready, frame_cnt}, {1'b1, 8'd1});
        @(negedge clk); s_valid = 0;
        chk("bp_second_frame", {i0, i1, i2, i3} & 8'h00, 8'h00);

        // 4: streaming at full rate
        do_reset();
        f_ready = 1;
        c0 = cyc;
        for (int k = 0; k < 40; k++) put(samp_t'(k % 4 - 2));
        chk("stream_cycles", cyc - c0, 40);
        @(negedge clk);
        chk("stream_cnt", {frame_cnt, 6'b0, frame_cnt2}, {8'd10, 6'b0, 2'd2});
        f_ready = 0;

        // 5: flush with a concurrent valid sample
        do_reset();
        put(-2); put(-2); put(-2);
        s_valid = 1; s_data = 2'b10; flush = 1;
        @(negedge clk); flush = 0; s_valid = 0;
        chk("flush_fvalid", f_valid, 0);
        put(1); put(1); put(1); put(1);
        chk("flush_frame", {f_valid, i0, i1, i2, i3}, {1'b1, 8'h55});

        // 6: frame counter wrap on the CNT_W=2 instance
        do_reset();
        f_ready = 1;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) put(samp_t'(f));
            @(negedge clk);
            chk("wrap_cnt", frame_cnt2, 32'(wrap_exp[f]));
        end
        f_ready = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
